ftc_bus_dec: RTL and testbench

//  Multi-group Forbidden-Transition-Code bus decoder. Receives GROUPS 4-bit FTC

---
 rtl/ftc_pkg.sv | 23 ++
 rtl/ftc_bus_dec_if.sv | 28 ++
 rtl/ftc_grp_dec.sv | 25 ++
 rtl/ftc_bus_dec.sv | 113 +++++++++++
 tb/tb_ftc_bus_dec.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ftc_pkg.sv
// Shared Forbidden-Transition-Code definitions used by the bus encoder and decoder.
// Holds the codeword/data widths and the 8-entry codebook, indexed by data value,
// plus a small encode helper so both ends of the link share one table.
package ftc_pkg;

    localparam int unsigned FTC_CODE_W    = 4;
    localparam int unsigned FTC_DATA_W    = 3;
    localparam int unsigned FTC_NUM_CODES = 8;

    typedef logic [FTC_CODE_W-1:0] ftc_code_t;
    typedef logic [FTC_DATA_W-1:0] ftc_data_t;

    // Entry i is the codeword that carries data value i.
    localparam ftc_code_t FTC_CODEBOOK [FTC_NUM_CODES] = '{
        4'b0000, 4'b0100, 4'b0001, 4'b0101,
        4'b0111, 4'b1100, 4'b1101, 4'b1111
    };

    function automatic ftc_code_t ftc_encode(input ftc_data_t data);
        return FTC_CODEBOOK[data];
    endfunction

endpackage

// File: rtl/ftc_bus_dec_if.sv
// Stream interface of the FTC bus decoder.
//  in_valid/in_ready/in_code     : codeword word from the wire capture flops
//  out_valid/out_ready/out_data  : decoded word towards the consumer
//  out_err                       : per-group invalid-codeword flags
// master drives codewords and consumes decoded data; slave is the decoder.
interface ftc_bus_dec_if #(
    parameter int unsigned GROUPS = 4
);

    logic                                     in_valid;
    logic                                     in_ready;
    logic [ftc_pkg::FTC_CODE_W*GROUPS-1:0]    in_code;
    logic                                     out_valid;
    logic                                     out_ready;
    logic [ftc_pkg::FTC_DATA_W*GROUPS-1:0]    out_data;
    logic [GROUPS-1:0]                        out_err;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/ftc_grp_dec.sv
// Combinational decoder for one 4-bit FTC codeword.
//  code    in  4  codeword
//  data    out 3  decoded value (0 when the codeword is not in the codebook)
//  code_ok out 1  codeword is a member of the codebook
module ftc_grp_dec
    import ftc_pkg::*;
(
    input  ftc_code_t code,
    output ftc_data_t data,
    output logic      code_ok
);

    always_comb begin
        data    = '0;
        code_ok = 1'b0;
        // Codebook entries are distinct, so at most one entry matches.
        for (int unsigned i = 0; i < FTC_NUM_CODES; i++) begin
            if (code == FTC_CODEBOOK[i]) begin
                data    = FTC_DATA_W'(i);
                code_ok = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ftc_bus_dec.sv
// Multi-group FTC bus decoder with a registered valid/ready output stage.
//  clk        in   rising-edge clock
//  rst        in   asynchronous reset, active high
//  bus        slave modport of ftc_bus_dec_if (codeword in, decoded word out)
//  clr_err    in   synchronous clear of err_sticky/err_cnt
//  err_sticky out  set by any accepted word with an invalid group
//  err_cnt    out  saturating count of accepted words with an invalid group
// HOLD_ON_ERR selects what an invalid group decodes to: 0 -> zero, 1 -> the
// last valid value seen on that group.
module ftc_bus_dec
    import ftc_pkg::*;
#(
    parameter int unsigned GROUPS      = 4,
    parameter int unsigned ERR_CNT_W   = 8,
    parameter bit          HOLD_ON_ERR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    ftc_bus_dec_if.slave         bus,
    input  logic                 clr_err,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned DW = FTC_DATA_W * GROUPS;

    logic [DW-1:0]        dec_data;
    logic [GROUPS-1:0]    dec_ok;
    logic [DW-1:0]        word_data;
    logic [GROUPS-1:0]    word_err;
    logic [DW-1:0]        hold_d, hold_q;
    logic [DW-1:0]        out_data_q;
    logic [GROUPS-1:0]    out_err_q;
    logic                 out_valid_q;
    logic                 accept;
    logic                 err_hit;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic                 err_sticky_d, err_sticky_q;

    for (genvar g = 0; g < GROUPS; g++) begin : g_dec
        ftc_grp_dec u_grp_dec (
            .code    (bus.in_code[g*FTC_CODE_W +: FTC_CODE_W]),
            .data    (dec_data[g*FTC_DATA_W +: FTC_DATA_W]),
            .code_ok (dec_ok[g])
        );
    end

    // Output register can take a new word when empty or being drained.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        word_data = '0;
        hold_d    = hold_q;
        for (int unsigned g = 0; g < GROUPS; g++) begin
            if (dec_ok[g]) begin
                word_data[g*FTC_DATA_W +: FTC_DATA_W] = dec_data[g*FTC_DATA_W +: FTC_DATA_W];
                hold_d[g*FTC_DATA_W +: FTC_DATA_W]    = dec_data[g*FTC_DATA_W +: FTC_DATA_W];
            end else if (HOLD_ON_ERR) begin
                word_data[g*FTC_DATA_W +: FTC_DATA_W] = hold_q[g*FTC_DATA_W +: FTC_DATA_W];
            end
        end
    end

    assign word_err = ~dec_ok;
    assign err_hit  = accept && (|word_err);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            hold_q      <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= word_data;
            out_err_q   <= word_err;
            hold_q      <= hold_d;
        end else if (bus.out_ready) begin
            // Drain: data stays, only the valid flag drops.
            out_valid_q <= 1'b0;
        end
    end

    // A clear that coincides with an erroneous accept keeps that new error.
    always_comb begin
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q | err_hit;
        if (clr_err) begin
            err_cnt_d    = err_hit ? ERR_CNT_W'(1) : '0;
            err_sticky_d = err_hit;
        end else if (err_hit && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign err_cnt       = err_cnt_q;
    assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_ftc_bus_dec.sv
// Bench for ftc_bus_dec: two instances (HOLD_ON_ERR=0 and =1) share one
// stimulus stream; a codebook-level model predicts both every cycle.
module tb_ftc_bus_dec;

    localparam int G       = 2;
    localparam int CW      = 2;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic [4*G-1:0]  in_code = '0;
    logic            out_ready = 1'b0;
    logic            clr_err = 1'b0;
    logic            err_sticky0, err_sticky1;
    logic [CW-1:0]   err_cnt0, err_cnt1;

    int total = 0;
    int bad   = 0;

    ftc_bus_dec_if #(.GROUPS(G)) bus0 ();
    ftc_bus_dec_if #(.GROUPS(G)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_code   = in_code;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_code   = in_code;
    assign bus1.out_ready = out_ready;

    ftc_bus_dec #(.GROUPS(G), .ERR_CNT_W(CW), .HOLD_ON_ERR(1'b0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus0),
        .clr_err    (clr_err),
        .err_sticky (err_sticky0),
        .err_cnt    (err_cnt0)
    );

    ftc_bus_dec #(.GROUPS(G), .ERR_CNT_W(CW), .HOLD_ON_ERR(1'b1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus1),
        .clr_err    (clr_err),
        .err_sticky (err_sticky1),
        .err_cnt    (err_cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Codebook as listed: returns -1 for codes outside it.
    function automatic int lookup(input logic [3:0] c);
        case (c)
            4'b0000: return 0;
            4'b0100: return 1;
            4'b0001: return 2;
            4'b0101: return 3;
            4'b0111: return 4;
            4'b1100: return 5;
            4'b1101: return 6;
            4'b1111: return 7;
            default: return -1;
        endcase
    endfunction

    // Model state
    logic           m_valid = 1'b0;
    logic [3*G-1:0] e_data0 = '0;
    logic [3*G-1:0] e_data1 = '0;
    logic [3*G-1:0] e_hold  = '0;
    logic [G-1:0]   e_err   = '0;
    int             m_cnt   = 0;
    logic           m_sticky = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic           acc, word_bad, nv, ns;
        logic [3*G-1:0] nd0, nd1, nh;
        logic [G-1:0]   ne;
        int             d, nc;
        if (rst) begin
            m_valid  <= 1'b0;
            e_data0  <= '0;
            e_data1  <= '0;
            e_hold   <= '0;
            e_err    <= '0;
            m_cnt    <= 0;
            m_sticky <= 1'b0;
        end else begin
            nd0 = e_data0; nd1 = e_data1; nh = e_hold; ne = e_err;
            nv = m_valid; nc = m_cnt; ns = m_sticky;
            acc = in_valid && (!m_valid || out_ready);
            word_bad = 1'b0;
            if (acc) begin
                for (int g = 0; g < G; g++) begin
                    d = lookup(in_code[4*g +: 4]);
                    if (d < 0) begin
                        ne[g] = 1'b1;
                        nd0[3*g +: 3] = 3'b000;
                        nd1[3*g +: 3] = e_hold[3*g +: 3];
                        word_bad = 1'b1;
                    end else begin
                        ne[g] = 1'b0;
                        nd0[3*g +: 3] = 3'(d);
                        nd1[3*g +: 3] = 3'(d);
                        nh[3*g +: 3]  = 3'(d);
                    end
                end
                nv = 1'b1;
            end else if (out_ready) begin
                nv = 1'b0;
            end
            if (clr_err) begin
                nc = word_bad ? 1 : 0;
                ns = word_bad;
            end else if (word_bad) begin
                ns = 1'b1;
                if (nc < CNT_MAX) nc = nc + 1;
            end
            m_valid  <= nv;
            e_data0  <= nd0;
            e_data1  <= nd1;
            e_hold   <= nh;
            e_err    <= ne;
            m_cnt    <= nc;
            m_sticky <= ns;
        end
    end

    always @(negedge clk) begin
        check("in_ready0",   32'(bus0.in_ready),  32'(!m_valid || out_ready));
        check("in_ready1",   32'(bus1.in_ready),  32'(!m_valid || out_ready));
        check("out_valid0",  32'(bus0.out_valid), 32'(m_valid));
        check("out_valid1",  32'(bus1.out_valid), 32'(m_valid));
        check("out_data0",   32'(bus0.out_data),  32'(e_data0));
        check("out_data1",   32'(bus1.out_data),  32'(e_data1));
        check("out_err0",    32'(bus0.out_err),   32'(e_err));
        check("out_err1",    32'(bus1.out_err),   32'(e_err));
        check("err_cnt0",    32'(err_cnt0),       32'(m_cnt));
        check("err_cnt1",    32'(err_cnt1),       32'(m_cnt));
        check("err_sticky0", 32'(err_sticky0),    32'(m_sticky));
        check("err_sticky1", 32'(err_sticky1),    32'(m_sticky));
    end

    // Advance past the next rising edge; outputs are settled on return.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  32'(bus0.out_valid), 32'd0);
        check("rst_data",   32'(bus1.out_data),  32'd0);
        check("rst_err",    32'(bus0.out_err),   32'd0);
        check("rst_cnt",    32'(err_cnt0),       32'd0);
        check("rst_sticky", 32'(err_sticky1),    32'd0);
        rst = 1'b0;
        step();

        // Sweep all code pairs at full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                in_code = {4'(a), 4'(b)};
                step();
            end
        end
        in_code = 8'b1100_0101;
        step();
        check("pin_data", 32'(bus0.out_data), 32'(6'b101_011));
        check("pin_err",  32'(bus0.out_err),  32'd0);
        in_valid = 1'b0;
        step();
        step();

        // Stall with a queued follow-up word
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'b0100_1111;
        step();
        check("stall_data", 32'(bus0.out_data), 32'(6'b001_111));
        in_code = 8'b0000_0101;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_hold", 32'(bus0.out_data), 32'(6'b001_111));
            check("stall_rdy",  32'(bus0.in_ready), 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("release_data", 32'(bus0.out_data), 32'(6'b000_011));
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(bus0.out_valid), 32'd0);
        check("drain_data",  32'(bus0.out_data),  32'(6'b000_011));

        // Hold-on-error behaviour
        in_valid = 1'b1;
        in_code  = 8'b0111_0001;
        step();
        check("hold_first", 32'(bus1.out_data), 32'(6'b100_010));
        in_code = 8'b0111_1000;
        step();
        check("hold_data1", 32'(bus1.out_data), 32'(6'b100_010));
        check("hold_err1",  32'(bus1.out_err),  32'(2'b01));
        check("hold_data0", 32'(bus0.out_data), 32'(6'b100_000));
        in_valid = 1'b0;
        step();

        // Counter saturation and clear
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_cnt", 32'(err_cnt0), 32'd0);
        in_valid = 1'b1;
        in_code  = 8'b0000_0010;
        repeat (5) step();
        in_valid = 1'b0;
        check("sat_cnt",    32'(err_cnt0),    32'd3);
        check("sat_sticky", 32'(err_sticky0), 32'd1);
        step();
        check("sat_cnt_hold", 32'(err_cnt1), 32'd3);

        // Clear coinciding with an erroneous accept
        clr_err  = 1'b1;
        in_valid = 1'b1;
        in_code  = 8'b1010_0000;
        step();
        clr_err  = 1'b0;
        in_valid = 1'b0;
        check("clr_hit_cnt",    32'(err_cnt0),    32'd1);
        check("clr_hit_sticky", 32'(err_sticky0), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_only_cnt",    32'(err_cnt0),    32'd0);
        check("clr_only_sticky", 32'(err_sticky0), 32'd0);
        step();

        // Reset while stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 8'b1111_1101;
        step();
        in_valid = 1'b0;
        step();
        check("pre_rst_valid", 32'(bus0.out_valid), 32'd1);
        check("pre_rst_data",  32'(bus0.out_data),  32'(6'b111_110));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus0.out_valid), 32'd0);
        check("mid_rst_data",  32'(bus0.out_data),  32'd0);
        check("mid_rst_err",   32'(bus1.out_err),   32'd0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_code   = 8'b0100_1100;
        step();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(bus0.out_valid), 32'd1);
        check("post_rst_data",  32'(bus0.out_data),  32'(6'b001_101));
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
